// File: rtl/auth_pkg.sv
// Shared definitions for the auth session arbiter: FSM encoding, ID width and request kinds.
package auth_pkg;

    localparam int AUTH_ID_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OWN     = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    localparam logic KIND_LOGIN  = 1'b0;
    localparam logic KIND_LOGOUT = 1'b1;

endpackage

// File: rtl/auth_session_arbiter_if.sv
// Terminal-side and engine-side signal bundle of the auth session arbiter.
interface auth_session_arbiter_if #(
    parameter int N_TERM = 4,
    parameter int ID_W   = 5
);
    logic [N_TERM-1:0]         term_enter;
    logic [4*N_TERM-1:0]       term_digit;
    logic [N_TERM-1:0]         term_logout;
    logic                      auth_enter;
    logic [3:0]                auth_digit;
    logic                      auth_gclogout;
    logic                      auth_login;
    logic                      auth_logout;
    logic [ID_W-1:0]           auth_id;
    logic                      grant_valid;
    logic [$clog2(N_TERM)-1:0] grant_idx;
    logic [N_TERM-1:0]         sess_active;
    logic [ID_W*N_TERM-1:0]    sess_id;

    modport master (
        input  term_enter, term_digit, term_logout, auth_login, auth_logout, auth_id,
        output auth_enter, auth_digit, auth_gclogout, grant_valid, grant_idx, sess_active, sess_id
    );

    modport slave (
        output term_enter, term_digit, term_logout, auth_login, auth_logout, auth_id,
        input  auth_enter, auth_digit, auth_gclogout, grant_valid, grant_idx, sess_active, sess_id
    );
endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin selector: first pending index at or after the pointer, wrapping.
module rr_picker #(
    parameter int N_TERM = 4,
    parameter int IDX_W  = 2
) (
    input  logic [N_TERM-1:0] i_pend,
    input  logic [IDX_W-1:0]  i_ptr,
    output logic [IDX_W-1:0]  o_idx,
    output logic              o_found
);
    int               w_j;
    logic [IDX_W-1:0] w_jidx;

    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        w_j     = 0;
        w_jidx  = '0;
        for (int k = 0; k < N_TERM; k++) begin
            w_j = int'(i_ptr) + k;
            if (w_j >= N_TERM) w_j = w_j - N_TERM;
            w_jidx = IDX_W'(w_j);
            if (!o_found && i_pend[w_jidx]) begin
                o_found = 1'b1;
                o_idx   = w_jidx;
            end
        end
    end
endmodule

// File: rtl/auth_session_arbiter.sv
// Round-robin owner of one shared auth engine across N_TERM terminals, with a per-terminal session table.
// Optional idle-grant abandonment is enabled by defining AUTH_TIMEOUT_EN.
module auth_session_arbiter
    import auth_pkg::*;
#(
    parameter int N_TERM      = 4,
    parameter int ID_W        = AUTH_ID_W,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic                   clk,
    input  logic                   rst,
    auth_session_arbiter_if.master bus
);
    localparam int IDX_W = $clog2(N_TERM);

    state_t            r_state, w_next;
    logic [N_TERM-1:0] r_pend, r_kind, r_sess_active;
    logic [ID_W-1:0]   r_sess_id [N_TERM];
    logic [IDX_W-1:0]  r_ptr, r_owner, w_pick_idx;
    logic              w_pick_found, r_own_kind;
    logic              r_auth_enter, r_gclogout;
    logic [3:0]        r_auth_digit;
    logic [3:0]        w_digit [N_TERM];
    logic              w_own_enter, w_own_active, w_fwd, w_timeout, w_engine_done;

    for (genvar g = 0; g < N_TERM; g++) begin : g_map
        assign w_digit[g] = bus.term_digit[4*g +: 4];
        assign bus.sess_id[ID_W*g +: ID_W] = r_sess_id[g];
    end

    assign w_own_enter   = bus.term_enter[r_owner];
    assign w_own_active  = r_sess_active[r_owner];
    assign w_fwd         = (r_state == ST_OWN) && (r_own_kind == KIND_LOGIN);
    assign w_engine_done = bus.auth_login || bus.auth_logout;

    rr_picker #(.N_TERM(N_TERM), .IDX_W(IDX_W)) u_pick (
        .i_pend  (r_pend),
        .i_ptr   (r_ptr),
        .o_idx   (w_pick_idx),
        .o_found (w_pick_found)
    );

`ifdef AUTH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] r_idle_cnt;

    // Counts cycles since the last enter seen on auth_enter (value 0 on that cycle).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                   r_idle_cnt <= '0;
        else if (r_state != ST_OWN) r_idle_cnt <= '0;
        else if (r_auth_enter)      r_idle_cnt <= CNT_W'(1);
        else                        r_idle_cnt <= r_idle_cnt + CNT_W'(1);
    end

    assign w_timeout = (r_state == ST_OWN) && (r_idle_cnt == CNT_W'(TIMEOUT_CYC - 1))
                       && !(w_fwd && w_own_enter);
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYC > 0);
    assign w_timeout        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (w_pick_found) w_next = ST_OWN;
            ST_OWN: begin
                if (w_engine_done)                                     w_next = ST_RELEASE;
                else if (r_own_kind == KIND_LOGOUT && !w_own_active)   w_next = ST_RELEASE;
                else if (w_timeout)                                    w_next = ST_RELEASE;
            end
            ST_RELEASE: w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.grant_valid   = (r_state == ST_OWN);
        bus.grant_idx     = (r_state == ST_OWN) ? r_owner : '0;
        bus.auth_enter    = r_auth_enter;
        bus.auth_digit    = r_auth_digit;
        bus.auth_gclogout = r_gclogout;
        bus.sess_active   = r_sess_active;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend        <= '0;
            r_kind        <= '0;
            r_ptr         <= '0;
            r_owner       <= '0;
            r_own_kind    <= KIND_LOGIN;
            r_auth_enter  <= 1'b0;
            r_auth_digit  <= '0;
            r_gclogout    <= 1'b0;
            r_sess_active <= '0;
            for (int i = 0; i < N_TERM; i++) r_sess_id[i] <= '0;
        end else begin
            r_auth_enter <= 1'b0;
            r_auth_digit <= '0;
            r_gclogout   <= 1'b0;

            // The first request pulse fixes the kind; repeats while pending are ignored.
            for (int i = 0; i < N_TERM; i++) begin
                if (r_state == ST_IDLE && w_pick_found && w_pick_idx == IDX_W'(i)) begin
                    r_pend[i] <= 1'b0;
                end else if (!r_pend[i] && (bus.term_enter[i] || bus.term_logout[i])
                             && !(r_state == ST_OWN && r_owner == IDX_W'(i))) begin
                    r_pend[i] <= 1'b1;
                    r_kind[i] <= bus.term_logout[i];
                end
            end

            case (r_state)
                ST_IDLE: if (w_pick_found) begin
                    r_owner    <= w_pick_idx;
                    r_own_kind <= r_kind[w_pick_idx];
                    if (r_kind[w_pick_idx] == KIND_LOGIN) begin
                        r_auth_enter <= 1'b1;
                        r_auth_digit <= w_digit[w_pick_idx];
                    end else if (r_sess_active[w_pick_idx]) begin
                        r_gclogout <= 1'b1;
                    end
                end
                ST_OWN: begin
                    if (w_fwd && w_next == ST_OWN) begin
                        r_auth_enter <= w_own_enter;
                        r_auth_digit <= w_digit[r_owner];
                    end
                    if (bus.auth_logout) begin
                        r_sess_active[r_owner] <= 1'b0;
                        r_sess_id[r_owner]     <= '0;
                    end else if (bus.auth_login) begin
                        r_sess_active[r_owner] <= 1'b1;
                        r_sess_id[r_owner]     <= bus.auth_id;
                    end else if (w_timeout) begin
                        r_gclogout <= 1'b1;
                    end
                end
                ST_RELEASE: r_ptr <= (r_owner == IDX_W'(N_TERM - 1)) ? '0 : r_owner + IDX_W'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_auth_session_arbiter.sv
// Directed self-checking bench for auth_session_arbiter (N_TERM=4, ID_W=5, TIMEOUT_CYC=16).
module tb_auth_session_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    auth_session_arbiter_if #(.N_TERM(4), .ID_W(5)) bus ();

    auth_session_arbiter #(.N_TERM(4), .ID_W(5), .TIMEOUT_CYC(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] sid(input int i);
        return bus.sess_id[i*5 +: 5];
    endfunction

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_inputs();
        bus.term_enter  = '0;
        bus.term_digit  = '0;
        bus.term_logout = '0;
        bus.auth_login  = 1'b0;
        bus.auth_logout = 1'b0;
        bus.auth_id     = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b0;
        step(2);
        rst = 1'b1;
        step(1);
    endtask

    task automatic pulse_enter(input logic [3:0] m);
        bus.term_enter = m;
        step();
        bus.term_enter = '0;
    endtask

    task automatic wait_grant(input int exp_idx, input string tag);
        int n = 0;
        while (!bus.grant_valid && n < 8) begin
            step();
            n++;
        end
        check({tag, "_valid"}, bus.grant_valid, 1);
        check({tag, "_idx"}, bus.grant_idx, exp_idx);
    endtask

    task automatic login(input int term, input logic [4:0] id, input string tag);
        pulse_enter(4'(1 << term));
        wait_grant(term, tag);
        bus.auth_id    = id;
        bus.auth_login = 1'b1;
        step();
        bus.auth_login = 1'b0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        clear_inputs();

        // Reset state, then reset in the middle of an ownership
        do_reset();
        rst = 1'b0;
        #1;
        check("rst_grant", bus.grant_valid, 0);
        check("rst_sess", bus.sess_active, 0);
        check("rst_gclo", bus.auth_gclogout, 0);
        rst = 1'b1;
        step();
        login(1, 5'd4, "t1_login");
        check("t1_active", bus.sess_active, 4'b0010);
        pulse_enter(4'b0010);
        wait_grant(1, "t1_own");
        rst = 1'b0;
        #1;
        check("t1_rst_grant", bus.grant_valid, 0);
        check("t1_rst_sess", bus.sess_active, 0);
        check("t1_rst_sid", sid(1), 0);
        check("t1_rst_enter", bus.auth_enter, 0);
        seen = 1'b0;
        repeat (2) begin
            step();
            seen |= bus.auth_gclogout;
        end
        rst = 1'b1;
        repeat (4) begin
            step();
            seen |= bus.grant_valid | bus.auth_gclogout;
        end
        check("t1_post_idle", seen, 0);

        // Single login on T2 with enter forwarding latency
        do_reset();
        bus.term_enter = 4'b0100;
        step();
        bus.term_enter = '0;
        check("t2_idle", bus.grant_valid, 0);
        step();
        check("t2_grant", bus.grant_valid, 1);
        check("t2_idx", bus.grant_idx, 2);
        check("t2_replay", bus.auth_enter, 1);
        step();
        check("t2_gap", bus.auth_enter, 0);
        bus.term_digit = 16'h0300;
        bus.term_enter = 4'b0100;
        step();
        bus.term_enter = '0;
        check("t2_ent3", bus.auth_enter, 1);
        check("t2_dig3", bus.auth_digit, 3);
        bus.term_digit = 16'h070E;
        step();
        check("t2_noent", bus.auth_enter, 0);
        check("t2_dig7", bus.auth_digit, 7);
        bus.term_enter = 4'b0100;
        step();
        bus.term_enter = '0;
        check("t2_ent7", bus.auth_enter, 1);
        bus.auth_id    = 5'd5;
        bus.auth_login = 1'b1;
        step();
        bus.auth_login = 1'b0;
        check("t2_release", bus.grant_valid, 0);
        check("t2_active", bus.sess_active, 4'b0100);
        check("t2_sid", sid(2), 5);
        check("t2_rel_enter", bus.auth_enter, 0);

        // Contention: T0,T1,T3 request together with pointer at 0
        do_reset();
        bus.term_digit = 16'hBEA1;
        pulse_enter(4'b1011);
        step();
        check("t3_g0", bus.grant_valid, 1);
        check("t3_i0", bus.grant_idx, 0);
        pulse_enter(4'b1010);
        check("t3_iso_en", bus.auth_enter, 0);
        check("t3_iso_dig", bus.auth_digit, 1);
        bus.auth_logout = 1'b1;
        step();
        bus.auth_logout = 1'b0;
        check("t3_rel0", bus.grant_valid, 0);
        step();
        check("t3_gap0", bus.grant_valid, 0);
        step();
        check("t3_g1", bus.grant_valid, 1);
        check("t3_i1", bus.grant_idx, 1);
        check("t3_dig1", bus.auth_digit, 4'hA);
        bus.auth_logout = 1'b1;
        step();
        bus.auth_logout = 1'b0;
        step(2);
        check("t3_g3", bus.grant_valid, 1);
        check("t3_i3", bus.grant_idx, 3);
        check("t3_dig3", bus.auth_digit, 4'hB);
        bus.auth_logout = 1'b1;
        step();
        bus.auth_logout = 1'b0;
        step(3);
        check("t3_drained", bus.grant_valid, 0);
        check("t3_nosess", bus.sess_active, 0);

        // Logout of an active session, then of an inactive one
        do_reset();
        login(1, 5'd9, "t4_login");
        check("t4_sid9", sid(1), 9);
        bus.term_logout = 4'b0010;
        step();
        bus.term_logout = '0;
        step();
        check("t4_own", bus.grant_idx, 1);
        check("t4_gclo", bus.auth_gclogout, 1);
        step();
        check("t4_gclo_once", bus.auth_gclogout, 0);
        check("t4_wait", bus.grant_valid, 1);
        bus.auth_logout = 1'b1;
        step();
        bus.auth_logout = 1'b0;
        check("t4_cleared", bus.sess_active, 0);
        check("t4_sid0", sid(1), 0);
        check("t4_rel", bus.grant_valid, 0);
        step();
        bus.term_logout = 4'b0100;
        step();
        bus.term_logout = '0;
        step();
        check("t4_in_own", bus.grant_valid, 1);
        check("t4_in_idx", bus.grant_idx, 2);
        check("t4_in_gclo", bus.auth_gclogout, 0);
        step();
        check("t4_in_rel", bus.grant_valid, 0);
        check("t4_in_gclo2", bus.auth_gclogout, 0);

        // Re-login overwrite, login/logout collision, spurious login while idle
        do_reset();
        login(0, 5'd6, "t5_a");
        check("t5_sid6", sid(0), 6);
        login(0, 5'd12, "t5_b");
        check("t5_sid12", sid(0), 12);
        pulse_enter(4'b0001);
        wait_grant(0, "t5_c");
        bus.auth_id     = 5'd3;
        bus.auth_login  = 1'b1;
        bus.auth_logout = 1'b1;
        step();
        bus.auth_login  = 1'b0;
        bus.auth_logout = 1'b0;
        check("t5_coll_act", bus.sess_active, 0);
        check("t5_coll_sid", sid(0), 0);
        step();
        bus.auth_login = 1'b1;
        step();
        bus.auth_login = 1'b0;
        check("t5_spur_act", bus.sess_active, 0);
        check("t5_spur_sid", sid(0), 0);
        check("t5_spur_grant", bus.grant_valid, 0);

        // Idle grant: abandoned after the timeout, or held forever without it
        do_reset();
        pulse_enter(4'b0001);
        wait_grant(0, "t6");
`ifdef AUTH_TIMEOUT_EN
        step(15);
        check("t6_hold15", bus.grant_valid, 1);
        check("t6_nogclo15", bus.auth_gclogout, 0);
        step();
        check("t6_gclo", bus.auth_gclogout, 1);
        check("t6_rel", bus.grant_valid, 0);
        step();
        check("t6_gclo_once", bus.auth_gclogout, 0);
        check("t6_sess", bus.sess_active, 0);
`else
        seen = 1'b0;
        repeat (40) begin
            step();
            seen |= bus.auth_gclogout | ~bus.grant_valid;
        end
        check("t6_held", seen, 0);
        bus.auth_logout = 1'b1;
        step();
        bus.auth_logout = 1'b0;
        check("t6_rel", bus.grant_valid, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
